// File: rtl/lc2k_alu_pkg.sv
// Shared encodings and helpers for the LC2K multi-cycle ALU.
package lc2k_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_NOR = 3'd1;
    localparam logic [2:0] OP_EQ  = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [2:0] op, input logic mul_en);
        return (op <= OP_SUB) || ((op == OP_MUL) && mul_en);
    endfunction

endpackage

// File: rtl/lc2k_alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_WIDTH cycles.
module lc2k_alu_mul_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic                  done_q, done_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = 1'b0;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Fixed iteration count; no early exit on a zero multiplier.
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/lc2k_alu_mc.sv
// LC2K multi-cycle ALU: handshake FSM, single-cycle ops and iterative MUL.
module lc2k_alu_mc
    import lc2k_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit MUL_EN     = 1'b1,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  eq_flag,
    output logic                  zero_flag,
    output logic                  illegal_op,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  valid_q, valid_d;
    logic                  eq_q, eq_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;

    logic                  accept;
    logic                  mul_start;
    logic                  mul_done;
    logic [DATA_WIDTH-1:0] mul_product;

    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL) && MUL_EN;

    lc2k_alu_mul_iter #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_W     (CNT_W)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        valid_d   = valid_q;
        eq_d      = eq_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    eq_d      = 1'b0;
                    illegal_d = 1'b0;
                    if (mul_start) begin
                        state_d = ST_MUL_RUN;
                    end else begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        if (!is_legal_op(op, MUL_EN)) begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end else begin
                            unique case (op)
                                OP_ADD:  result_d = a + b;
                                OP_NOR:  result_d = ~(a | b);
                                OP_SUB:  result_d = a - b;
                                default: begin
                                    result_d = '0;
                                    eq_d     = (a == b);
                                end
                            endcase
                        end
                        zero_d = (result_d == '0);
                    end
                end
            end
            ST_MUL_RUN: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    valid_d  = 1'b1;
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            valid_q   <= 1'b0;
            eq_q      <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            eq_q      <= eq_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && !reset;
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = valid_q;
    assign result     = result_q;
    assign eq_flag    = eq_q;
    assign zero_flag  = zero_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_lc2k_alu_mc.sv
// Directed bench for lc2k_alu_mc: handshake, ops, MUL latency, reset, illegal ops.
module tb_lc2k_alu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_valid2, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b;

    logic        in_ready, out_valid, eq_flag, zero_flag, illegal_op, busy;
    logic [31:0] result;
    logic        in_ready2, out_valid2, eq_flag2, zero_flag2, illegal_op2, busy2;
    logic [31:0] result2;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    lc2k_alu_mc #(.DATA_WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .eq_flag(eq_flag), .zero_flag(zero_flag),
        .illegal_op(illegal_op), .busy(busy)
    );

    lc2k_alu_mc #(.DATA_WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .eq_flag(eq_flag2), .zero_flag(zero_flag2),
        .illegal_op(illegal_op2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic eeq,
                          input logic ez, input logic eill);
        @(negedge clk);
        check({tag, "_rdy0"}, 32'(in_ready), 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, result, er);
        check({tag, "_eq"}, 32'(eq_flag), 32'(eeq));
        check({tag, "_zero"}, 32'(zero_flag), 32'(ez));
        check({tag, "_ill"}, 32'(illegal_op), 32'(eill));
        check({tag, "_rdy1"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_mul(input string tag, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] er,
                           input logic pulse);
        int lat;
        int bad;
        lat = 0;
        bad = 0;
        @(negedge clk);
        op = 3'd4; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = 32'h0000_0001; b = 32'h0000_0001;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            op = 3'd0;
            in_valid = pulse && (k >= 3) && (k <= 8);
            @(posedge clk);
            #1 lat = k;
            if (out_valid) break;
            if (in_ready || !busy) bad++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'd33);
        check({tag, "_hs"}, 32'(bad), 32'd0);
        check({tag, "_res"}, result, er);
        check({tag, "_zero"}, 32'(zero_flag), 32'(er == 32'd0));
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_flags", {28'd0, eq_flag, zero_flag, illegal_op, busy}, 32'd0);
        @(negedge clk) reset = 1'b0;
        #1 check("rst_rdy", 32'(in_ready), 32'd1);

        run_op("add", 3'd0, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0006, 0, 0, 0);
        run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 0, 1, 0);
        run_op("eq_t", 3'd2, 32'h1234, 32'h1234, 32'h0, 1, 1, 0);
        run_op("eq_f", 3'd2, 32'h1234, 32'h1235, 32'h0, 0, 1, 0);
        run_op("nor", 3'd1, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, 0, 0, 0);
        run_op("nor0", 3'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
        run_op("sub", 3'd3, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 0);
        run_op("sub_z", 3'd3, 32'd5, 32'd5, 32'h0, 0, 1, 0);

        run_mul("mul", 32'h0001_0003, 32'h0001_0002, 32'h0005_0006, 1'b1);
        run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_mul("mul_0", 32'h0, 32'h1234_5678, 32'h0, 1'b0);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        @(negedge clk);
        op = 3'd0; a = 32'd2; b = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_vld", 32'(out_valid), 32'd1);
            check("bp_res", result, 32'd4);
            check("bp_rdy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_vld", 32'(out_valid), 32'd0);
        check("bp_rel_busy", 32'(busy), 32'd0);
        check("bp_rel_res", result, 32'd4);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        op = 3'd4; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("mrst_busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mrst_res", result, 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_vld", 32'(out_valid), 32'd0);
        @(negedge clk) reset = 1'b0;

        run_op("ill6", 3'd6, 32'd9, 32'd9, 32'h0, 0, 1, 1);
        run_op("ill_clr", 3'd0, 32'd1, 32'd1, 32'd2, 0, 0, 0);
        run_mul("mul_post", 32'd3, 32'd5, 32'd15, 1'b0);

        // MUL opcode on a build without the multiplier.
        @(negedge clk);
        op = 3'd4; a = 32'd3; b = 32'd5; in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        check("nomul_vld", 32'(out_valid2), 32'd1);
        check("nomul_ill", 32'(illegal_op2), 32'd1);
        check("nomul_res", result2, 32'd0);
        check("nomul_rdy", 32'(in_ready2), 32'd0);
        @(posedge clk);
        #1 check("nomul_idle", 32'(out_valid2), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
